// File: rtl/retire_trace_buffer.sv
// retire_trace_buffer
//   Captures retire records from the RV32I pipeline into a circular buffer.
//   A debug host drains the records over a first-word-fall-through read port.
//   Capture starts after arming. It can optionally wait for a PC match, and it
//   stops when commanded.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   update_i + fields     retire strobe and the retired record fields
//   arm_i, stop_i, clr_i  session control pulses
//   trig_en_i, trig_pc_i  optional PC-match trigger
//   rec_valid_o/ready_i   read handshake; rec_* present the head record
//   state_o, count_o, overflow_o, drop_cnt_o, retired_cnt_o   status
//
// Handshake: a record transfers on a rising edge where rec_valid_o and
// rec_ready_i are both high. rec_valid_o never depends on rec_ready_i. The
// head fields stay stable while rec_valid_o=1 and rec_ready_i=0.
module retire_trace_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     update_i,
  input  logic [XLEN-1:0]          pc_i,
  input  logic [XLEN-1:0]          instr_i,
  input  logic [4:0]               reg_addr_i,
  input  logic [XLEN-1:0]          reg_data_i,
  input  logic [XLEN-1:0]          mem_addr_i,
  input  logic [XLEN-1:0]          mem_data_i,
  input  logic                     mem_wrt_i,
  input  logic                     arm_i,
  input  logic                     stop_i,
  input  logic                     clr_i,
  input  logic                     trig_en_i,
  input  logic [XLEN-1:0]          trig_pc_i,
  output logic                     rec_valid_o,
  input  logic                     rec_ready_i,
  output logic [XLEN-1:0]          rec_pc_o,
  output logic [XLEN-1:0]          rec_instr_o,
  output logic [XLEN-1:0]          rec_rd_data_o,
  output logic [XLEN-1:0]          rec_mem_addr_o,
  output logic [XLEN-1:0]          rec_mem_data_o,
  output logic [4:0]               rec_rd_o,
  output logic                     rec_mem_wrt_o,
  output logic [1:0]               state_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic [15:0]              drop_cnt_o,
  output logic [31:0]              retired_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd_data;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data;
    logic            mem_wrt;
  } rec_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_RUN   = 2'b10
  } state_t;

  state_t          state_q;
  rec_t            mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     drop_q, drop_d;
  logic [31:0]     ret_q, ret_d;

  logic trig_hit, push, pop, full, wr_en, drop;
  rec_t rec_in, head;

  assign rec_in = '{pc: pc_i, instr: instr_i, rd: reg_addr_i, rd_data: reg_data_i,
                    mem_addr: mem_addr_i, mem_data: mem_data_i, mem_wrt: mem_wrt_i};

  always_comb begin
    trig_hit = (state_q == S_ARMED) && update_i && (pc_i == trig_pc_i);
    full     = (count_q == CW'(DEPTH));
    // clr_i discards any same-cycle traffic. stop_i ends capture immediately,
    // but draining still proceeds.
    pop      = (count_q != '0) && rec_ready_i && !clr_i;
    push     = update_i && !stop_i && !clr_i && ((state_q == S_RUN) || trig_hit);
    // A full buffer accepts a new record only when a pop frees a slot this cycle.
    wr_en    = push && (!full || pop);
    drop     = push && full && !pop;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;
    ret_d    = ret_q + 32'(update_i);
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      drop_d   = '0;
      ret_d    = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(wr_en) - CW'(pop);
      if (drop) begin
        ovf_d = 1'b1;
        if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      end
    end
  end

  // Session FSM. clr_i freezes the state. stop_i overrides both arm and trigger.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else if (!clr_i) begin
      if (stop_i) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE:  if (arm_i)    state_q <= trig_en_i ? S_ARMED : S_RUN;
          S_ARMED: if (trig_hit) state_q <= S_RUN;
          S_RUN:   state_q <= S_RUN;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
      ret_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
      ret_q    <= ret_d;
    end
  end

  // The record storage needs no reset. Slots are read only when count says so.
  always_ff @(posedge clk_i) begin
    if (wr_en && !rst_i) mem_q[wr_ptr_q] <= rec_in;
  end

  assign head           = mem_q[rd_ptr_q];
  assign rec_valid_o    = (count_q != '0);
  assign rec_pc_o       = head.pc;
  assign rec_instr_o    = head.instr;
  assign rec_rd_o       = head.rd;
  assign rec_rd_data_o  = head.rd_data;
  assign rec_mem_addr_o = head.mem_addr;
  assign rec_mem_data_o = head.mem_data;
  assign rec_mem_wrt_o  = head.mem_wrt;
  assign state_o        = state_q;
  assign count_o        = count_q;
  assign overflow_o     = ovf_q;
  assign drop_cnt_o     = drop_q;
  assign retired_cnt_o  = ret_q;

endmodule

// File: doc/retire_trace_buffer.md
# retire_trace_buffer

Captures per-instruction retire records from the RV32I pipeline's retire/debug outputs into a circular buffer. A debug host drains them over a valid/ready read port. Capture starts after arming, optionally gated by a PC-match trigger, and stops on command. The block sits beside the core top-level, on the consuming end of the retire interface.

## Interface
- XLEN, 32: datapath width.
- DEPTH, 16: record slots; power of two, at least 2.
- clk_i  in  1  system clock.
- rst_i  in  1  reset, synchronous, active-high; one clock.
- update_i  in  1  retire strobe, sampled high on a rising edge = one retire event.
- pc_i, instr_i  in  XLEN each  retired PC and retired instruction.
- reg_addr_i  in  5  destination register.
- reg_data_i  in  XLEN  writeback data.
- mem_addr_i, mem_data_i  in  XLEN each  data-memory address and data.
- mem_wrt_i  in  1  memory write flag.
- arm_i  in  1  one-cycle pulse; starts a capture session.
- stop_i  in  1  one-cycle pulse; ends capture.
- clr_i  in  1  flush buffer and counters.
- trig_en_i  in  1  1 = wait for PC match before capturing.
- trig_pc_i  in  XLEN  trigger PC.
- rec_valid_o  out  1  head record available.
- rec_ready_i  in  1  host consumes head.
- rec_pc_o, rec_instr_o, rec_rd_data_o, rec_mem_addr_o, rec_mem_data_o  out  XLEN each  head record fields.
- rec_rd_o  out  5  head record destination register.
- rec_mem_wrt_o  out  1  head record memory write flag.
- state_o  out  2  00 IDLE, 01 ARMED, 10 RUN.
- count_o  out  $clog2(DEPTH)+1  occupancy.
- overflow_o  out  1  sticky; set when a record is dropped.
- drop_cnt_o  out  16  dropped records; saturates at 0xFFFF.
- retired_cnt_o  out  32  every update_i seen, in any state; wraps.

## Operation
- Record = {pc, instr, reg_addr, reg_data, mem_addr, mem_data, mem_wrt}, 166 bits. It is stored in a DEPTH-entry array with write and read pointers that wrap modulo DEPTH.
- FSM transitions:
  - IDLE –arm_i→ ARMED if trig_en_i=1, else → RUN.
  - ARMED –(update_i & pc_i==trig_pc_i)→ RUN. The trigger record itself is captured.
  - ARMED or RUN –stop_i→ IDLE. stop_i has priority over a same-cycle trigger or arm.
  - arm_i is ignored outside IDLE.
- Push when state==RUN & update_i, or on the trigger cycle in ARMED.
- Pop when rec_valid_o & rec_ready_i. rec_valid_o = (count != 0).
- Full buffer (count==DEPTH) and push without a same-cycle pop:
  - The new record is dropped and the oldest is kept.
  - overflow_o is set and drop_cnt_o increments, saturating.
- Full buffer with push and pop in the same cycle: both happen and count is unchanged.
- Empty buffer with push: the record is written; the pop side is inactive that cycle.
- Records already captured stay readable in IDLE; draining continues after stop.
- clr_i:
  - Clears the pointers, count, overflow_o and drop_cnt_o. retired_cnt_o is also cleared.
  - FSM state is unchanged.
  - A same-cycle push or pop is discarded.
- Priority: rst_i > clr_i > stop_i > arm_i/trigger > push/pop.

## Timing
- Reset values: state_o=IDLE; count_o=0; rec_valid_o=0; overflow_o=0; drop_cnt_o=0; retired_cnt_o=0.
- Record fields (rec_pc_o through rec_mem_wrt_o) are don't-care while rec_valid_o=0. The bench checks them only when rec_valid_o=1.
- Capture latency: a record sampled on edge N appears at the head with rec_valid_o=1 after edge N, if the buffer was empty.
- Read port is first-word-fall-through. Head fields are stable while rec_valid_o=1 & rec_ready_i=0. After a pop on edge N, the next record is presented after edge N.
- state_o and all status outputs are registered and update on the edge that causes the change.
- Reset mid-session: all contents are lost. The FSM returns to IDLE on the next edge, ignoring other inputs that cycle.

## Test plan
- Basic capture: arm_i with trig_en_i=0, then 3 retires with pc 0x0, 0x4, 0x8 while rec_ready_i=0 → count_o=3. Raise rec_ready_i → records drain in order with rec_pc_o 0x0, 0x4, 0x8, then rec_valid_o=0.
- PC trigger: trig_en_i=1, trig_pc_i=0x10, arm, retire PCs 0x0 through 0x18 step 4 → state ARMED until 0x10. Captured PCs are 0x10, 0x14, 0x18. retired_cnt_o=7.
- Overflow (DEPTH=16): 20 retires in RUN with no reads → count_o=16, overflow_o=1, drop_cnt_o=4. The head is the first record.
- Full with simultaneous push and pop: count stays 16, drop_cnt_o stays 0, FIFO order is preserved.
- Stop, clear and reset:
  - stop_i and arm_i in the same cycle → IDLE; later retires are not captured.
  - clr_i with 5 records stored → count_o=0 and counters 0.
  - rst_i during RUN → all reset values on the next edge.
